// File: rtl/fe_reset_scheduler.sv
// fe_reset_scheduler: schedules non-destructive FE resets and arbitrates the chip command line
// between the host command path and the FE reset engine.
module fe_reset_scheduler #(
    parameter int          PER_W = 32,
    parameter int          QUIET = 16,
    parameter int unsigned TMO   = 20'hFFFFF,
    parameter int          TMO_W = 20
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Enable,
    input  logic [PER_W-1:0] Period,
    input  logic             ManReq,
    input  logic             CmdBusy,
    input  logic             TrgBusy,
    input  logic             HostCmd,
    input  logic             RstCmd,
    input  logic             RstDone,
    output logic             Cmd,
    output logic             RstStart,
    output logic             Hold,
    output logic             Active,
    output logic             TmoErr,
    output logic [7:0]       NRst
);
    localparam int QW = $clog2(QUIET + 1);

    typedef enum logic [5:0] {
        S_IDLE = 6'b000001,
        S_REQ  = 6'b000010,
        S_STRT = 6'b000100,
        S_RUN  = 6'b001000,
        S_FIN  = 6'b010000,
        S_TOUT = 6'b100000
    } state_t;

    state_t           r_state;
    logic             r_pend;
    logic             r_owner;
    logic [PER_W-1:0] r_percnt;
    logic [QW-1:0]    r_qcnt;
    logic [TMO_W-1:0] r_tcnt;

    logic w_quiet;
    logic w_cnt_en;
    logic w_tick;
    logic w_tmo;
    logic w_run_exit;

    assign w_quiet    = !CmdBusy && !TrgBusy;
    assign w_cnt_en   = r_state == S_IDLE && Enable && Period != '0;
    assign w_tick     = w_cnt_en && r_percnt == Period - PER_W'(1);
    assign w_tmo      = r_tcnt == TMO_W'(TMO - 1);
    assign w_run_exit = r_state == S_RUN && (RstDone || w_tmo);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state  <= S_IDLE;
            r_pend   <= 1'b0;
            r_owner  <= 1'b0;
            r_percnt <= '0;
            r_qcnt   <= '0;
            r_tcnt   <= '0;
            Cmd      <= 1'b0;
            RstStart <= 1'b0;
            Hold     <= 1'b0;
            Active   <= 1'b0;
            TmoErr   <= 1'b0;
            NRst     <= '0;
        end else begin
            Cmd      <= r_owner ? RstCmd : HostCmd;
            RstStart <= 1'b0;
            // A request landing on the STRT cycle survives the clear
            r_pend   <= ManReq || w_tick || (r_pend && r_state != S_STRT);
            if (!Enable || w_run_exit)
                r_percnt <= '0;
            else if (w_cnt_en)
                r_percnt <= w_tick ? '0 : r_percnt + PER_W'(1);
            case (r_state)
                S_IDLE: begin
                    if (r_pend) begin
                        r_state <= S_REQ;
                        Hold    <= 1'b1;
                        Active  <= 1'b1;
                        r_qcnt  <= '0;
                    end
                end
                S_REQ: begin
                    if (!w_quiet)
                        r_qcnt <= '0;
                    else if (r_qcnt == QW'(QUIET - 1)) begin
                        r_state  <= S_STRT;
                        RstStart <= 1'b1;
                    end else
                        r_qcnt <= r_qcnt + QW'(1);
                end
                S_STRT: begin
                    r_owner <= 1'b1;
                    r_tcnt  <= '0;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    r_tcnt <= r_tcnt + TMO_W'(1);
                    if (RstDone)
                        r_state <= S_FIN;
                    else if (w_tmo)
                        r_state <= S_TOUT;
                end
                S_FIN: begin
                    NRst    <= NRst + 8'd1;
                    r_owner <= 1'b0;
                    Hold    <= 1'b0;
                    Active  <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_TOUT: begin
                    TmoErr  <= 1'b1;
                    r_owner <= 1'b0;
                    Hold    <= 1'b0;
                    Active  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_owner <= 1'b0;
                    Hold    <= 1'b0;
                    Active  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fe_reset_scheduler.sv
// tb_fe_reset_scheduler: directed scenarios plus randomized traffic, each cycle compared
// against a phase-level reference model of the scheduler.
module tb_fe_reset_scheduler;
    localparam int QUIET = 16;
    localparam int TMO   = 1000;
    localparam int P_IDLE = 0, P_REQ = 1, P_STRT = 2, P_RUN = 3, P_FIN = 4, P_TOUT = 5;

    logic        Clock = 1'b0;
    logic        Reset, Enable, ManReq, CmdBusy, TrgBusy, HostCmd, RstCmd, RstDone;
    logic [31:0] Period;
    logic        Cmd, RstStart, Hold, Active, TmoErr;
    logic [7:0]  NRst;

    int checks = 0;
    int errors = 0;

    // reference model: phase of the reset sequence plus plain counters
    int          ph, quiet, runlen, nrst;
    bit          pend, tmo, cmd_e;
    logic [31:0] percnt;

    fe_reset_scheduler #(.PER_W(32), .QUIET(QUIET), .TMO(TMO), .TMO_W(20)) dut (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .Period(Period),
        .ManReq(ManReq), .CmdBusy(CmdBusy), .TrgBusy(TrgBusy),
        .HostCmd(HostCmd), .RstCmd(RstCmd), .RstDone(RstDone),
        .Cmd(Cmd), .RstStart(RstStart), .Hold(Hold), .Active(Active),
        .TmoErr(TmoErr), .NRst(NRst)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 20) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_step();
        bit p, tick, owner;
        if (Reset) begin
            ph = P_IDLE; pend = 0; percnt = 0; quiet = 0; runlen = 0;
            nrst = 0; tmo = 0; cmd_e = 0;
            return;
        end
        p     = pend;
        owner = ph == P_RUN || ph == P_FIN || ph == P_TOUT;
        cmd_e = owner ? RstCmd : HostCmd;
        tick  = ph == P_IDLE && Enable && Period != 0 && percnt == Period - 32'd1;
        if (!Enable || (ph == P_RUN && (RstDone || runlen + 1 == TMO))) percnt = 0;
        else if (ph == P_IDLE && Period != 0) percnt = tick ? 32'd0 : percnt + 32'd1;
        pend = ManReq || tick || (p && ph != P_STRT);
        case (ph)
            P_IDLE: if (p) begin ph = P_REQ; quiet = 0; end
            P_REQ: begin
                quiet = (CmdBusy || TrgBusy) ? 0 : quiet + 1;
                if (quiet == QUIET) ph = P_STRT;
            end
            P_STRT: begin ph = P_RUN; runlen = 0; end
            P_RUN: begin
                runlen++;
                if (RstDone) ph = P_FIN;
                else if (runlen == TMO) ph = P_TOUT;
            end
            P_FIN: begin nrst = (nrst + 1) % 256; ph = P_IDLE; end
            default: begin tmo = 1; ph = P_IDLE; end
        endcase
    endfunction

    task automatic step();
        model_step();
        @(posedge Clock);
        #1;
        chk("cmd", Cmd, cmd_e);
        chk("rststart", RstStart, ph == P_STRT);
        chk("hold", Hold, ph != P_IDLE);
        chk("active", Active, ph != P_IDLE);
        chk("tmoerr", TmoErr, tmo);
        chk("nrst", NRst, nrst % 256);
    endtask

    task automatic until_start(input int blip_at, output int n);
        n = 0;
        do begin
            n++;
            TrgBusy = n == blip_at;
            step();
        end while (!RstStart && n < 200);
        TrgBusy = 0;
    endtask

    task automatic finish_run(input int len);
        repeat (len) step();
        RstDone = 1; step(); RstDone = 0;
        repeat (2) step();
    endtask

    task automatic man_req();
        ManReq = 1; step(); ManReq = 0;
    endtask

    int n, cnt, pm, pb, pd;

    initial begin
        Reset = 1; Enable = 0; Period = 0; ManReq = 0; CmdBusy = 0; TrgBusy = 0;
        HostCmd = 0; RstCmd = 0; RstDone = 0;
        repeat (2) step();
        chk("rst_nrst", NRst, 0);
        chk("rst_hold", Hold, 0);
        Reset = 0;

        // periodic request, then command-line ownership around the run
        Period = 100; Enable = 1;
        n = 0;
        do begin n++; step(); end while (!Hold && n < 300);
        chk("t1_hold_at", n, 101);
        while (!RstStart && n < 400) begin n++; step(); end
        chk("t1_start_at", n, 101 + QUIET);
        Enable = 0;
        repeat (50) step();
        HostCmd = 1; RstCmd = 0; step();
        chk("t3_run_host_blocked", Cmd, 0);
        HostCmd = 0; RstCmd = 1; step();
        chk("t3_run_rstcmd", Cmd, 1);
        RstDone = 1; step(); RstDone = 0; RstCmd = 0; step();
        chk("t1_nrst", NRst, 1);
        chk("t1_hold_off", Hold, 0);
        HostCmd = 1; step();
        chk("t3_idle_hostcmd", Cmd, 1);
        HostCmd = 0; RstCmd = 1; step();
        chk("t3_idle_rst_blocked", Cmd, 0);
        RstCmd = 0;

        // quiet window after a long host command, with and without a trigger blip
        ManReq = 1; CmdBusy = 1; step(); ManReq = 0; repeat (29) step(); CmdBusy = 0;
        until_start(0, n);
        chk("t2_quiet_len", n, QUIET);
        finish_run(20);
        ManReq = 1; CmdBusy = 1; step(); ManReq = 0; repeat (29) step(); CmdBusy = 0;
        until_start(11, n);
        chk("t2_blip_len", n, 10 + 1 + QUIET);
        finish_run(20);
        chk("t2_nrst", NRst, 3);

        // timeout, then a normal reset still completes
        man_req();
        until_start(0, n);
        n = 0;
        do begin n++; step(); end while (!TmoErr && n < 1100);
        chk("t4_tmo_at", n, TMO + 2);
        chk("t4_hold", Hold, 0);
        chk("t4_nrst", NRst, 3);
        man_req();
        until_start(0, n);
        finish_run(10);
        chk("t4_after_nrst", NRst, 4);
        chk("t4_sticky", TmoErr, 1);

        // requests merged while busy: exactly one more reset
        man_req();
        until_start(0, n);
        man_req();
        repeat (3) begin repeat (5) step(); man_req(); end
        repeat (5) step();
        RstDone = 1; step(); RstDone = 0; step();
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            RstDone = i % 40 == 39;
            step();
            cnt += RstStart;
        end
        RstDone = 0;
        chk("t5_one_more", cnt, 1);
        chk("t5_nrst", NRst, 6);

        // reset in the middle of a run
        man_req();
        until_start(0, n);
        RstCmd = 1; repeat (5) step();
        Reset = 1; step(); Reset = 0; RstCmd = 0;
        chk("t6_cmd", Cmd, 0);
        chk("t6_start", RstStart, 0);
        chk("t6_hold", Hold, 0);
        chk("t6_active", Active, 0);
        chk("t6_tmoerr", TmoErr, 0);
        chk("t6_nrst", NRst, 0);
        Period = 0; Enable = 1; cnt = 0;
        repeat (300) begin step(); cnt += Hold; end
        chk("t6_no_periodic", cnt, 0);

        // randomized traffic against the model
        for (int s = 0; s < 16; s++) begin
            Enable = $urandom_range(0, 3) != 0;
            Period = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom_range(1, 300);
            pm = $urandom_range(0, 30);
            pb = $urandom_range(0, 30);
            pd = (s % 4 == 3) ? 0 : $urandom_range(1, 80);
            for (int i = 0; i < 1200; i++) begin
                ManReq  = $urandom_range(0, 999) < pm;
                CmdBusy = $urandom_range(0, 99) < pb;
                TrgBusy = $urandom_range(0, 99) < pb / 3;
                HostCmd = 1'($urandom);
                RstCmd  = 1'($urandom);
                RstDone = $urandom_range(0, 999) < pd;
                Reset   = $urandom_range(0, 1999) == 0;
                if ($urandom_range(0, 499) == 0) Period = $urandom_range(1, 300);
                step();
            end
        end
        Reset = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
